// File: rtl/ram1_port_arbiter_if.sv
// Bus bundle between the core/PIM fabric, the RAM1 IP and the RAM1 port arbiter.
// Core: riscv_rstrb / riscv_wmask are one-cycle strobes, and the access is done when riscv_rbusy / riscv_wbusy drop.
// PIM: pim_req (valid) is held with its fields stable until pim_gnt (ready), and reads return with a pim_rvalid pulse.
interface ram1_port_arbiter_if;
  logic [31:0] riscv_addr;
  logic [31:0] riscv_wdata;
  logic [3:0]  riscv_wmask;
  logic        riscv_rstrb;
  logic [31:0] riscv_rdata;
  logic        riscv_rbusy;
  logic        riscv_wbusy;

  logic        pim_req;
  logic        pim_we;
  logic [9:0]  pim_addr;
  logic [31:0] pim_wdata;
  logic [3:0]  pim_be;
  logic        pim_gnt;
  logic        pim_rvalid;
  logic [31:0] pim_rdata;
  logic        pim_sel;

  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wen;
  logic        ram_rden;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_rdata;

  logic [1:0]  dbg_state;

  // The slave side is the arbiter. The master side is the fabric together with the RAM.
  modport slave (
    input  riscv_addr, riscv_wdata, riscv_wmask, riscv_rstrb,
    input  pim_req, pim_we, pim_addr, pim_wdata, pim_be, pim_sel,
    input  ram_rdata,
    output riscv_rdata, riscv_rbusy, riscv_wbusy,
    output pim_gnt, pim_rvalid, pim_rdata,
    output ram_addr, ram_wdata, ram_wen, ram_rden, ram_byteena,
    output dbg_state
  );

  modport master (
    output riscv_addr, riscv_wdata, riscv_wmask, riscv_rstrb,
    output pim_req, pim_we, pim_addr, pim_wdata, pim_be, pim_sel,
    output ram_rdata,
    input  riscv_rdata, riscv_rbusy, riscv_wbusy,
    input  pim_gnt, pim_rvalid, pim_rdata,
    input  ram_addr, ram_wdata, ram_wen, ram_rden, ram_byteena,
    input  dbg_state
  );
endinterface

// File: rtl/ram1_port_arbiter.sv
// Arbitrates the single-port RAM1 between the RISC-V core data bus and the PIM engine.
// It latches core strobes, applies round-robin or PIM-exclusive arbitration, and sequences the RAM read latency.
module ram1_port_arbiter #(
  parameter int BANK_BIT = 12,
  parameter int RD_LAT   = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  ram1_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {GNT_CORE = 1'b0, GNT_PIM = 1'b1} owner_t;

  state_t      state, state_nx;
  owner_t      last_grant, rd_owner;
  logic [1:0]  lat_cnt, lat_cnt_nx;
  logic        rd_pend, wr_pend;
  logic [9:0]  core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wmask;
  logic [31:0] riscv_rdata_q, pim_rdata_q;
  logic        pim_rvalid_q;

  logic        cs, core_rd_stb, core_wr_stb, core_req;
  logic        arb_slot, grant_pim, grant_core, rd_done;
  logic [9:0]  ram_addr_c;
  logic [31:0] ram_wdata_c;
  logic        ram_wen_c, ram_rden_c;
  logic [3:0]  ram_byteena_c;
  logic        addr_unused;

  assign cs          = bus.riscv_addr[BANK_BIT];
  assign addr_unused = ^bus.riscv_addr;
  // Stalls and grants are gated by reset so that every output reads 0 while reset is held.
  assign core_rd_stb = reset_n & bus.riscv_rstrb & cs;
  assign core_wr_stb = reset_n & (|bus.riscv_wmask) & cs;
  assign core_req    = rd_pend | wr_pend;
  assign arb_slot    = reset_n & ((state == IDLE) | (state == RESP));
  assign rd_done     = (state == RD_WAIT) & (lat_cnt == 2'd0);

  always_comb begin
    grant_pim  = 1'b0;
    grant_core = 1'b0;
    if (arb_slot) begin
      if (bus.pim_req && core_req && !bus.pim_sel) begin
        grant_pim  = (last_grant == GNT_CORE);
        grant_core = (last_grant == GNT_PIM);
      end else begin
        grant_pim  = bus.pim_req;
        grant_core = core_req & ~bus.pim_sel;
      end
    end
  end

  always_comb begin
    ram_addr_c    = '0;
    ram_wdata_c   = '0;
    ram_wen_c     = 1'b0;
    ram_rden_c    = 1'b0;
    ram_byteena_c = '0;
    if (grant_pim) begin
      ram_addr_c    = bus.pim_addr;
      ram_wen_c     = bus.pim_we;
      ram_rden_c    = ~bus.pim_we;
      ram_wdata_c   = bus.pim_we ? bus.pim_wdata : 32'h0;
      ram_byteena_c = bus.pim_we ? bus.pim_be : 4'hF;
    end else if (grant_core) begin
      ram_addr_c    = core_addr;
      ram_wen_c     = wr_pend;
      ram_rden_c    = ~wr_pend;
      ram_wdata_c   = wr_pend ? core_wdata : 32'h0;
      ram_byteena_c = wr_pend ? core_wmask : 4'hF;
    end
  end

  // RESP behaves like IDLE so that a new access can issue back-to-back with a response.
  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        if (ram_rden_c) begin
          state_nx   = RD_WAIT;
          lat_cnt_nx = 2'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 2'd0) state_nx = RESP;
        else                 lat_cnt_nx = lat_cnt - 2'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      last_grant    <= GNT_CORE;
      rd_owner      <= GNT_CORE;
      rd_pend       <= 1'b0;
      wr_pend       <= 1'b0;
      core_addr     <= '0;
      core_wdata    <= '0;
      core_wmask    <= '0;
      riscv_rdata_q <= '0;
      pim_rdata_q   <= '0;
      pim_rvalid_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      lat_cnt      <= lat_cnt_nx;
      pim_rvalid_q <= 1'b0;
      if (grant_pim)       last_grant <= GNT_PIM;
      else if (grant_core) last_grant <= GNT_CORE;
      if (ram_rden_c) rd_owner <= grant_pim ? GNT_PIM : GNT_CORE;
      if (grant_core && wr_pend) wr_pend <= 1'b0;
      // ram_rdata becomes valid RD_LAT cycles after ram_rden, which is the last RD_WAIT cycle.
      if (rd_done) begin
        if (rd_owner == GNT_PIM) begin
          pim_rdata_q  <= bus.ram_rdata;
          pim_rvalid_q <= 1'b1;
        end else begin
          riscv_rdata_q <= bus.ram_rdata;
          rd_pend       <= 1'b0;
        end
      end
      if (!core_req) begin
        if (core_wr_stb) begin
          wr_pend    <= 1'b1;
          core_addr  <= bus.riscv_addr[11:2];
          core_wdata <= bus.riscv_wdata;
          core_wmask <= bus.riscv_wmask;
        end else if (core_rd_stb) begin
          rd_pend   <= 1'b1;
          core_addr <= bus.riscv_addr[11:2];
        end
      end
    end
  end

  assign bus.riscv_rdata = riscv_rdata_q;
  assign bus.riscv_rbusy = core_rd_stb | rd_pend;
  assign bus.riscv_wbusy = core_wr_stb | wr_pend;
  assign bus.pim_gnt     = grant_pim;
  assign bus.pim_rvalid  = pim_rvalid_q;
  assign bus.pim_rdata   = pim_rdata_q;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_wdata   = ram_wdata_c;
  assign bus.ram_wen     = ram_wen_c;
  assign bus.ram_rden    = ram_rden_c;
  assign bus.ram_byteena = ram_byteena_c;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_ram1_port_arbiter.sv
// Directed bench for ram1_port_arbiter with a behavioural RAM1 model, a PIM read scoreboard and a grant-order log.
module tb_ram1_port_arbiter;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rden_cnt = 0;
  int   wen_cnt = 0;
  int   rvalid_cnt = 0;
  logic [31:0] exp_q[$];
  logic        grant_log[$];
  logic [3:0]  last_wr_be = 4'h0;
  logic [31:0] mem [1024];
  logic [31:0] merge_w;
  bit          mem_ready = 1'b0;

  logic [9:0]  pim_rd_addr [8] = '{10'h004, 10'h008, 10'h009, 10'h00A, 10'h00B, 10'h00C, 10'h3FF, 10'h000};
  logic [31:0] pim_rd_exp  [8] = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h44444444,
                                   32'h55555555, 32'h33333333, 32'h00000000, 32'h00000000};

  ram1_port_arbiter_if bus();

  ram1_port_arbiter #(.BANK_BIT(12), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // RAM1 model: byte-enabled write, read data one cycle after ram_rden.
  always @(posedge clk) begin
    if (!mem_ready) begin
      foreach (mem[i]) mem[i] <= 32'h0;
      mem_ready <= 1'b1;
    end else begin
      if (bus.ram_wen) begin
        merge_w = mem[bus.ram_addr];
        for (int b = 0; b < 4; b++)
          if (bus.ram_byteena[b]) merge_w[8*b +: 8] = bus.ram_wdata[8*b +: 8];
        mem[bus.ram_addr] <= merge_w;
      end
      if (bus.ram_rden) bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Monitor and scoreboard for PIM read data
  always @(negedge clk) begin
    if (reset_n && (bus.ram_wen || bus.ram_rden)) grant_log.push_back(bus.pim_gnt);
    if (bus.ram_rden) rden_cnt++;
    if (bus.ram_wen) begin
      wen_cnt++;
      last_wr_be = bus.ram_byteena;
    end
    if (bus.pim_rvalid) begin
      rvalid_cnt++;
      if (exp_q.size() == 0) check_eq("pim_rvalid_unexpected", 32'(bus.pim_rvalid), 32'd0);
      else check_eq("pim_rdata", bus.pim_rdata, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.riscv_addr  = '0;
    bus.riscv_wdata = '0;
    bus.riscv_wmask = '0;
    bus.riscv_rstrb = 1'b0;
    bus.pim_req     = 1'b0;
    bus.pim_we      = 1'b0;
    bus.pim_addr    = '0;
    bus.pim_wdata   = '0;
    bus.pim_be      = '0;
    bus.pim_sel     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rbusy"},   32'(bus.riscv_rbusy), 32'd0);
    check_eq({tag, "_wbusy"},   32'(bus.riscv_wbusy), 32'd0);
    check_eq({tag, "_rdata"},   bus.riscv_rdata, 32'd0);
    check_eq({tag, "_pim_gnt"}, 32'(bus.pim_gnt), 32'd0);
    check_eq({tag, "_rvalid"},  32'(bus.pim_rvalid), 32'd0);
    check_eq({tag, "_pim_rd"},  bus.pim_rdata, 32'd0);
    check_eq({tag, "_ram_ctl"}, 32'({bus.ram_wen, bus.ram_rden, bus.ram_byteena, bus.ram_addr}), 32'd0);
    check_eq({tag, "_ram_wd"},  bus.ram_wdata, 32'd0);
    check_eq({tag, "_state"},   32'(bus.dbg_state), 32'd0);
  endtask

  task automatic core_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n;
    bus.riscv_addr  = a;
    bus.riscv_wdata = d;
    bus.riscv_wmask = m;
    next_cycle();
    bus.riscv_wmask = 4'h0;
    n = 0;
    @(negedge clk);
    while (bus.riscv_wbusy && n < 50) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("core_write_done", 32'(bus.riscv_wbusy), 32'd0);
    next_cycle();
  endtask

  task automatic core_read(input logic [31:0] a, output logic [31:0] d, output int busy);
    int n;
    busy = 0;
    bus.riscv_addr  = a;
    bus.riscv_rstrb = 1'b1;
    @(negedge clk);
    if (bus.riscv_rbusy) busy++;
    next_cycle();
    bus.riscv_rstrb = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.riscv_rbusy && n < 50) begin
      busy++;
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("core_read_done", 32'(bus.riscv_rbusy), 32'd0);
    d = bus.riscv_rdata;
    next_cycle();
  endtask

  // Holds pim_req until granted and returns with pim_req still high for the caller to chain or drop.
  task automatic pim_access(input logic we, input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] exp);
    int n;
    bus.pim_req   = 1'b1;
    bus.pim_we    = we;
    bus.pim_addr  = a;
    bus.pim_wdata = d;
    bus.pim_be    = be;
    n = 0;
    @(negedge clk);
    while (!bus.pim_gnt && n < 50) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("pim_gnt", 32'(bus.pim_gnt), 32'd1);
    if (!we && bus.pim_gnt) exp_q.push_back(exp);
    next_cycle();
  endtask

  task automatic wait_pim_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 50) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("pim_drain", 32'(exp_q.size()), 32'd0);
    next_cycle();
  endtask

  initial begin
    logic [31:0] rd;
    int busy;
    int n;
    int ones;

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Core write 0x1010 with cycle-exact checks.
    bus.riscv_addr  = 32'h0000_1010;
    bus.riscv_wdata = 32'hDEADBEEF;
    bus.riscv_wmask = 4'hF;
    @(negedge clk);
    check_eq("wr_stall_strobe", 32'(bus.riscv_wbusy), 32'd1);
    check_eq("wr_no_wen_c0", 32'(bus.ram_wen), 32'd0);
    next_cycle();
    bus.riscv_wmask = 4'h0;
    @(negedge clk);
    check_eq("wr_wen_c1", 32'(bus.ram_wen), 32'd1);
    check_eq("wr_addr_c1", 32'(bus.ram_addr), 32'h004);
    check_eq("wr_wdata_c1", bus.ram_wdata, 32'hDEADBEEF);
    check_eq("wr_be_c1", 32'(bus.ram_byteena), 32'hF);
    check_eq("wr_stall_c1", 32'(bus.riscv_wbusy), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("wr_free_c2", 32'(bus.riscv_wbusy), 32'd0);
    check_eq("wr_wen_off_c2", 32'(bus.ram_wen), 32'd0);
    next_cycle();

    // Core read 0x1010 with cycle-exact checks.
    bus.riscv_addr  = 32'h0000_1010;
    bus.riscv_rstrb = 1'b1;
    @(negedge clk);
    check_eq("rd_stall_c0", 32'(bus.riscv_rbusy), 32'd1);
    check_eq("rd_no_rden_c0", 32'(bus.ram_rden), 32'd0);
    next_cycle();
    bus.riscv_rstrb = 1'b0;
    @(negedge clk);
    check_eq("rd_rden_c1", 32'(bus.ram_rden), 32'd1);
    check_eq("rd_addr_c1", 32'(bus.ram_addr), 32'h004);
    check_eq("rd_be_c1", 32'(bus.ram_byteena), 32'hF);
    next_cycle();
    @(negedge clk);
    check_eq("rd_stall_c2", 32'(bus.riscv_rbusy), 32'd1);
    check_eq("rd_rden_off_c2", 32'(bus.ram_rden), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("rd_free_c3", 32'(bus.riscv_rbusy), 32'd0);
    check_eq("rd_data_c3", bus.riscv_rdata, 32'hDEADBEEF);
    next_cycle();

    core_read(32'h0000_1010, rd, busy);
    check_eq("rd_busy_cycles", 32'(busy), 32'd3);
    check_eq("rd_again_data", rd, 32'hDEADBEEF);

    // Accesses outside the RAM1 bank are ignored.
    n = rden_cnt;
    core_read(32'h0000_0010, rd, busy);
    check_eq("bank0_rd_busy", 32'(busy), 32'd0);
    check_eq("bank0_rd_no_rden", 32'(rden_cnt), 32'(n));
    n = wen_cnt;
    bus.riscv_addr  = 32'h0000_0010;
    bus.riscv_wmask = 4'hF;
    @(negedge clk);
    check_eq("bank0_wr_busy", 32'(bus.riscv_wbusy), 32'd0);
    next_cycle();
    bus.riscv_wmask = 4'h0;
    repeat (2) next_cycle();
    check_eq("bank0_wr_no_wen", 32'(wen_cnt), 32'(n));

    // Contention with last_grant = CORE: PIM wins, core follows.
    grant_log.delete();
    fork
      core_write(32'h0000_1020, 32'h11111111, 4'hF);
      begin
        next_cycle();
        pim_access(1'b1, 10'h009, 32'h22222222, 4'hF, 32'h0);
        bus.pim_req = 1'b0;
      end
    join
    check_eq("rr1_count", 32'(grant_log.size()), 32'd2);
    check_eq("rr1_first_pim", 32'(grant_log[0]), 32'd1);
    check_eq("rr1_then_core", 32'(grant_log[1]), 32'd0);

    // PIM keeps requesting: grants alternate P, C, P.
    grant_log.delete();
    fork
      core_write(32'h0000_1030, 32'h33333333, 4'hF);
      begin
        next_cycle();
        pim_access(1'b1, 10'h00A, 32'h44444444, 4'hF, 32'h0);
        pim_access(1'b1, 10'h00B, 32'h55555555, 4'hF, 32'h0);
        bus.pim_req = 1'b0;
      end
    join
    check_eq("rr2_count", 32'(grant_log.size()), 32'd3);
    check_eq("rr2_g0_pim", 32'(grant_log[0]), 32'd1);
    check_eq("rr2_g1_core", 32'(grant_log[1]), 32'd0);
    check_eq("rr2_g2_pim", 32'(grant_log[2]), 32'd1);

    // PIM-exclusive phase: 8 back-to-back reads while a core read waits.
    bus.pim_sel = 1'b1;
    next_cycle();
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) pim_access(1'b0, pim_rd_addr[i], 32'h0, 4'h0, pim_rd_exp[i]);
        bus.pim_req = 1'b0;
      end
      begin
        bus.riscv_addr  = 32'h0000_1010;
        bus.riscv_rstrb = 1'b1;
        next_cycle();
        bus.riscv_rstrb = 1'b0;
      end
    join
    wait_pim_drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("core_held_by_sel", 32'(bus.riscv_rbusy), 32'd1);
      next_cycle();
    end
    ones = 0;
    foreach (grant_log[i]) if (grant_log[i]) ones++;
    check_eq("sel_only_pim_grants", 32'(ones), 32'd8);
    check_eq("sel_grant_count", 32'(grant_log.size()), 32'd8);
    bus.pim_sel = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.ram_rden && n < 10) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("core_issue_after_sel", 32'({bus.ram_rden, bus.pim_gnt}), 32'b10);
    check_eq("core_issue_latency", 32'(n < 2), 32'd1);
    n = 0;
    next_cycle();
    @(negedge clk);
    while (bus.riscv_rbusy && n < 50) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("core_after_sel_done", 32'(bus.riscv_rbusy), 32'd0);
    check_eq("core_after_sel_data", bus.riscv_rdata, 32'hDEADBEEF);
    next_cycle();

    // Partial byte write merges into existing word.
    core_write(32'h0000_1040, 32'h11223344, 4'hF);
    core_write(32'h0000_1040, 32'h00AB0000, 4'b0100);
    check_eq("mask_byteena", 32'(last_wr_be), 32'h4);
    core_read(32'h0000_1040, rd, busy);
    check_eq("mask_merge_data", rd, 32'h11AB3344);

    // Reset during RD_WAIT aborts the PIM read with no response.
    n = rvalid_cnt;
    bus.pim_req  = 1'b1;
    bus.pim_we   = 1'b0;
    bus.pim_addr = 10'h009;
    @(negedge clk);
    check_eq("abort_pim_gnt", 32'(bus.pim_gnt), 32'd1);
    next_cycle();
    bus.pim_req = 1'b0;
    @(negedge clk);
    check_eq("abort_in_rd_wait", 32'(bus.dbg_state), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) next_cycle();
    reset_n = 1'b1;
    repeat (3) next_cycle();
    check_eq("abort_no_rvalid", 32'(rvalid_cnt), 32'(n));

    // Service resumes normally after the abort.
    pim_access(1'b0, 10'h009, 32'h0, 4'h0, 32'h22222222);
    bus.pim_req = 1'b0;
    wait_pim_drain();
    core_read(32'h0000_1010, rd, busy);
    check_eq("post_reset_rd_data", rd, 32'hDEADBEEF);
    check_eq("post_reset_rd_busy", 32'(busy), 32'd3);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram1_port_arbiter.md
Name: ram1_port_arbiter

Overview:
- Shares the single-port RAM1 IP (1024 x 32, byte-enabled) between two masters: the RISC-V core data bus and the PIM engine.
- Sits between the core/PIM fabric and the RAM IP. It latches one-cycle core strobes, arbitrates access, and sequences RAM read latency.
- Returns stall signals and read data to each master.
- When pim_sel is high, the PIM engine has exclusive ownership for the duration of a PIM compute phase.

Parameters:
- BANK_BIT, 12, core address bit that selects RAM1 when high.
- RD_LAT, 1, cycles from ram_rden to valid ram_rdata (1..3).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- riscv_addr  in  32  core byte address; word index is riscv_addr[11:2]
- riscv_wdata  in  32  core write data
- riscv_wmask  in  4  core byte write mask; nonzero means write strobe
- riscv_rstrb  in  1  core read strobe (one-cycle pulse)
- riscv_rdata  out  32  core read data
- riscv_rbusy  out  1  core read stall
- riscv_wbusy  out  1  core write stall
- pim_req  in  1  PIM access request, held until pim_gnt
- pim_we  in  1  PIM write (1) / read (0)
- pim_addr  in  10  PIM word address
- pim_wdata  in  32  PIM write data
- pim_be  in  4  PIM byte enables
- pim_gnt  out  1  one-cycle pulse: PIM request accepted and issued to RAM
- pim_rvalid  out  1  one-cycle pulse: pim_rdata valid
- pim_rdata  out  32  PIM read data
- pim_sel  in  1  PIM exclusive-ownership mode
- ram_addr  out  10  RAM word address
- ram_wdata  out  32  RAM write data
- ram_wen  out  1  RAM write enable
- ram_rden  out  1  RAM read enable
- ram_byteena  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data

Behaviour:
- Reset (async, reset_n low): FSM enters IDLE; core pending flags clear; last_grant is CORE; lat_cnt is 0; all outputs are 0. Reset mid-transaction aborts it with no response.
- Core capture: cs = riscv_addr[BANK_BIT].
  - A read strobe (riscv_rstrb & cs) sets rd_pend and latches the address.
  - A write strobe (|riscv_wmask & cs) sets wr_pend and latches address, data and mask.
  - Strobes with cs = 0 are ignored.
  - Strobes while a core request is already pending are ignored; the core never issues them.
- Stalls:
  - riscv_rbusy = (riscv_rstrb & cs) | rd_pend.
  - riscv_wbusy = (|riscv_wmask & cs) | wr_pend.
  - Both are combinational, so the stall is visible in the strobe cycle.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: selects one requester and drives the RAM for exactly one cycle.
    - A write asserts ram_wen and returns to IDLE. A PIM write pulses pim_gnt; a core write clears wr_pend at the clock edge.
    - A read asserts ram_rden, loads lat_cnt = RD_LAT-1, pulses pim_gnt if the read is a PIM read, then goes to RD_WAIT.
  - RD_WAIT: decrements lat_cnt; at 0 goes to RESP.
  - RESP: the owner's read data is registered from ram_rdata.
    - PIM owner: pim_rvalid = 1 in the next cycle.
    - Core owner: riscv_rdata is updated and rd_pend clears, so rbusy drops in the next cycle with data valid.
    - Returns to IDLE. New arbitration is allowed in RESP (back-to-back).
  - RAM outputs are 0 whenever no access is issued.
- Arbitration:
  - pim_sel = 1: the core is never granted and its requests stay pending.
  - pim_sel = 0 with both masters requesting: round-robin against last_grant. With a single requester it is granted immediately.
  - The core presents its own read and write to the arbiter as one request.
  - pim_sel changes take effect only at the next grant decision. An in-flight access always completes.
- Latency at RD_LAT = 1, no contention:
  - Core read: strobe at cycle 0, ram_rden at cycle 1, rbusy low with data at cycle 3.
  - Core write: ram_wen at cycle 1, wbusy low at cycle 2.
- Byte mask: ram_byteena = riscv_wmask for core writes, pim_be for PIM writes, 4'hF for reads.

Test Plan:
- Core write addr 0x1010, wdata 0xDEADBEEF, wmask 4'hF, then read 0x1010 -> ram_wen with ram_addr=10'h004; read returns 0xDEADBEEF with rbusy high for exactly 3 cycles.
- Core read addr 0x0010 (bit 12 = 0) -> no ram_rden, rbusy stays 0.
- PIM and core requests in the same cycle, pim_sel = 0, last_grant = CORE -> PIM granted first, core issued on the next arbitration; repeat -> order alternates.
- pim_sel = 1 with 8 back-to-back PIM reads while the core strobes a read -> core rbusy held high until pim_sel drops, then core served within 2 cycles.
- Core write wmask 4'b0100, wdata 0x00AB0000 over 0x11223344 -> read returns 0x11AB3344.
- reset_n pulsed low during RD_WAIT -> all outputs 0 immediately, no pim_rvalid, next request served normally.
